// File: rtl/sa_ctrl.sv
// sa_ctrl: host-side controller for a SIZE x SIZE systolic array.
// A job loads B and A rows from the host row stream into a local buffer,
// pushes B (reversed) and then A into the array, waits for the array's
// pipeline to produce C = A x B, captures the result rows and streams
// them back to the host.
// Optional build macro: SA_CTRL_VLD_CHECK_EN adds a sticky o_err output
// that flags a result-valid strobe from the array arriving in the wrong
// cycle.
module sa_ctrl #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_row_vld,
  output logic                  o_row_rdy,
  input  logic [SIZE*WIDTH-1:0] i_row,
  output logic                  o_sa_we,
  output logic                  o_sa_a_vld,
  output logic                  o_sa_c_vld,
  output logic [SIZE*WIDTH-1:0] o_sa_a_rows,
  input  logic                  i_sa_c_vld,
  input  logic [SIZE*WIDTH-1:0] i_sa_c_rows,
`ifdef SA_CTRL_VLD_CHECK_EN
  output logic                  o_err,
`endif
  output logic                  o_res_vld,
  input  logic                  i_res_rdy,
  output logic [SIZE*WIDTH-1:0] o_res_row,
  output logic                  o_res_last
);

  localparam int RW    = SIZE * WIDTH;
  localparam int NROWS = 2 * SIZE;
  localparam int CW    = $clog2(2 * SIZE + 1);

  // Terminal counts for each phase; the WAIT value is only used when SIZE > 1.
  localparam logic [CW-1:0] LAST_FILL = CW'(NROWS - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(SIZE - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'((SIZE > 1) ? (SIZE - 2) : 0);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PUSH_B,
    PUSH_A,
    WAIT,
    CAPT,
    DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_buf_we;
  logic            w_res_we;
  logic [CW-1:0]   w_buf_idx;
  logic [RW-1:0]   w_buf_rd;
  logic [RW-1:0]   w_res_rd;

  // Rows 0..SIZE-1 hold B, rows SIZE..2*SIZE-1 hold A.
  logic [RW-1:0]   r_buf [NROWS];
  logic [RW-1:0]   r_res [SIZE];

  // State, phase counter and done pulse; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Row buffer write: FILL stores each accepted host row at the counter slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NROWS; i++) begin
      if (w_buf_we && (r_cnt == CW'(i))) begin
        r_buf[i] <= i_row;
      end
    end
  end

  // Result buffer write: CAPT stores one array result row per cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (w_res_we && (r_cnt == CW'(i))) begin
        r_res[i] <= i_sa_c_rows;
      end
    end
  end

  // Buffer read index: B is pushed last-row-first, A in natural order.
  always_comb begin
    if (r_state == PUSH_B) begin
      w_buf_idx = LAST_ROW - r_cnt;
    end else begin
      w_buf_idx = CW'(SIZE) + r_cnt;
    end
  end

  // Read multiplexers for the row buffer and the result buffer.
  always_comb begin
    w_buf_rd = '0;
    w_res_rd = '0;
    for (int i = 0; i < NROWS; i++) begin
      if (w_buf_idx == CW'(i)) begin
        w_buf_rd = r_buf[i];
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      if (r_cnt == CW'(i)) begin
        w_res_rd = r_res[i];
      end
    end
  end

  // Next-state logic and all Moore/handshake outputs of the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_buf_we    = 1'b0;
    w_res_we    = 1'b0;
    o_row_rdy   = 1'b0;
    o_sa_we     = 1'b0;
    o_sa_a_vld  = 1'b0;
    o_sa_c_vld  = 1'b0;
    o_sa_a_rows = '0;
    o_res_vld   = 1'b0;
    o_res_last  = 1'b0;
    o_res_row   = '0;
    o_busy      = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
        end
      end

      FILL: begin
        o_row_rdy = 1'b1;
        if (i_row_vld) begin
          w_buf_we = 1'b1;
          if (r_cnt == LAST_FILL) begin
            w_state_nxt = PUSH_B;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      PUSH_B: begin
        o_sa_a_vld  = 1'b1;
        o_sa_a_rows = w_buf_rd;
        o_sa_we     = (r_cnt == LAST_ROW);
        if (r_cnt == LAST_ROW) begin
          w_state_nxt = PUSH_A;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      PUSH_A: begin
        o_sa_a_vld  = 1'b1;
        o_sa_c_vld  = 1'b1;
        o_sa_a_rows = w_buf_rd;
        if (r_cnt == LAST_ROW) begin
          w_state_nxt = (SIZE > 1) ? WAIT : CAPT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      WAIT: begin
        if (r_cnt == LAST_WAIT) begin
          w_state_nxt = CAPT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      CAPT: begin
        w_res_we = 1'b1;
        if (r_cnt == LAST_ROW) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DRAIN: begin
        o_res_vld  = 1'b1;
        o_res_row  = w_res_rd;
        o_res_last = (r_cnt == LAST_ROW);
        if (i_res_rdy) begin
          if (r_cnt == LAST_ROW) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_done = r_done;

`ifdef SA_CTRL_VLD_CHECK_EN
  logic r_err;

  // Sticky error: the array must strobe result-valid exactly during CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (((r_state == CAPT) && !i_sa_c_vld) ||
                 (((r_state == PUSH_B) || (r_state == PUSH_A) ||
                   (r_state == WAIT)) && i_sa_c_vld)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  // The result-valid strobe only feeds the optional checker.
  logic w_unused_c_vld;
  assign w_unused_c_vld = i_sa_c_vld;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: randomized scoreboard bench for sa_ctrl (SIZE=3, WIDTH=16).
// Contains a behavioural systolic-array model that multiplies the pushed
// A rows by the pushed B matrix and returns each row 2*SIZE-1 cycles later.
module tb_sa_ctrl;

  localparam int W  = 16;
  localparam int S  = 3;
  localparam int RW = S * W;

  typedef logic [RW-1:0] row_t;
  typedef row_t mat_t [S];
  typedef struct packed {row_t rows; logic we; logic cvld;} arr_exp_t;
  typedef struct packed {row_t row; logic last;} res_exp_t;
  typedef struct packed {int due; row_t row;} sch_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start;
  logic o_busy;
  logic o_done;
  logic i_row_vld;
  logic o_row_rdy;
  row_t i_row;
  logic o_sa_we;
  logic o_sa_a_vld;
  logic o_sa_c_vld;
  row_t o_sa_a_rows;
  logic i_sa_c_vld;
  row_t i_sa_c_rows;
  logic o_res_vld;
  logic i_res_rdy;
  row_t o_res_row;
  logic o_res_last;
`ifdef SA_CTRL_VLD_CHECK_EN
  logic o_err;
`endif

  always #5 clk = ~clk;

  sa_ctrl #(.WIDTH(W), .SIZE(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_row_vld   (i_row_vld),
    .o_row_rdy   (o_row_rdy),
    .i_row       (i_row),
    .o_sa_we     (o_sa_we),
    .o_sa_a_vld  (o_sa_a_vld),
    .o_sa_c_vld  (o_sa_c_vld),
    .o_sa_a_rows (o_sa_a_rows),
    .i_sa_c_vld  (i_sa_c_vld),
    .i_sa_c_rows (i_sa_c_rows),
`ifdef SA_CTRL_VLD_CHECK_EN
    .o_err       (o_err),
`endif
    .o_res_vld   (o_res_vld),
    .i_res_rdy   (i_res_rdy),
    .o_res_row   (o_res_row),
    .o_res_last  (o_res_last)
  );

  arr_exp_t arrQ[$];
  res_exp_t resQ[$];
  int nVec = 0;
  int nFail = 0;
  int cyc = 0;
  int doneCnt = 0;

  // Model/monitor state
  row_t bq[$];
  sch_t sched[$];
  bit   inA = 0;
  bit   expectPushB = 0;
  bit   prevStall = 0;
  row_t prevRow = '0;
  int   fillCount = 0;
  int   lastFillCyc = 0;
  int   lastResCyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // C row = a x m, computed with plain integer arithmetic, wrapped to W bits.
  function automatic row_t vecMat(input row_t a, input mat_t m);
    row_t r;
    int sum;
    r = '0;
    for (int j = 0; j < S; j++) begin
      sum = 0;
      for (int k = 0; k < S; k++) begin
        sum += int'($signed(a[k*W +: W])) * int'($signed(m[k][j*W +: W]));
      end
      r[j*W +: W] = W'(sum);
    end
    return r;
  endfunction

  task automatic mkFixed(output mat_t m);
    for (int r = 0; r < S; r++) begin
      m[r] = '0;
      for (int j = 0; j < S; j++) m[r][j*W +: W] = W'(r * S + j + 1);
    end
  endtask

  task automatic mkRandom(output mat_t m);
    for (int r = 0; r < S; r++) begin
      m[r] = '0;
      for (int j = 0; j < S; j++) m[r][j*W +: W] = W'($urandom);
    end
  endtask

  // Array model plus scoreboard monitor, both evaluated mid-cycle.
  always @(negedge clk) begin : mon
    arr_exp_t ea;
    res_exp_t er;
    mat_t bm;
    sch_t sc;
    cyc++;
    if (!rst_n) begin
      sched.delete();
      bq.delete();
      inA = 0;
      expectPushB = 0;
      prevStall = 0;
      fillCount = 0;
      i_sa_c_vld = 1'b0;
      i_sa_c_rows = '0;
    end else begin
      // Array model: collect B (last pushed is row 0), multiply A rows.
      if (o_sa_a_vld && !o_sa_c_vld) begin
        if (inA) begin
          bq.delete();
          inA = 0;
        end
        bq.push_front(o_sa_a_rows);
      end
      if (o_sa_a_vld && o_sa_c_vld) begin
        inA = 1;
        for (int r = 0; r < S; r++) bm[r] = (r < bq.size()) ? bq[r] : '0;
        sc.due = cyc + 2 * S - 1;
        sc.row = vecMat(o_sa_a_rows, bm);
        sched.push_back(sc);
      end
      if (sched.size() > 0 && sched[0].due == cyc) begin
        sc = sched.pop_front();
        i_sa_c_vld = 1'b1;
        i_sa_c_rows = sc.row;
      end else begin
        i_sa_c_vld = 1'b0;
        i_sa_c_rows = '0;
      end

      // Array-side strobes against expected push sequence.
      if (expectPushB && o_sa_a_vld && !o_sa_c_vld) begin
        checkOutput("pushb_start", 64'(cyc), 64'(lastFillCyc + 1));
        expectPushB = 0;
      end
      if (o_sa_a_vld) begin
        if (arrQ.size() == 0) begin
          checkOutput("arr_unexpected", 64'(1), 64'(0));
        end else begin
          ea = arrQ.pop_front();
          checkOutput("arr_seq", 64'({o_sa_a_rows, o_sa_we, o_sa_c_vld}), 64'(ea));
        end
      end else begin
        checkOutput("arr_idle", 64'({o_sa_a_rows, o_sa_we, o_sa_c_vld}), 64'(0));
      end

      // Host row handshakes.
      if (o_row_rdy && i_row_vld) begin
        lastFillCyc = cyc;
        fillCount++;
        if (fillCount == 2 * S) begin
          fillCount = 0;
          expectPushB = 1;
        end
      end

      // Result stream.
      if (o_res_vld) begin
        if (prevStall) checkOutput("res_stable", 64'(o_res_row), 64'(prevRow));
        if (i_res_rdy) begin
          lastResCyc = cyc;
          if (resQ.size() == 0) begin
            checkOutput("res_unexpected", 64'(1), 64'(0));
          end else begin
            er = resQ.pop_front();
            checkOutput("res_row", 64'({o_res_row, o_res_last}), 64'(er));
          end
        end
      end
      prevStall = o_res_vld && !i_res_rdy;
      prevRow = o_res_row;

      if (o_done) begin
        doneCnt++;
        checkOutput("done_timing", 64'(cyc), 64'(lastResCyc + 1));
        checkOutput("done_idle", 64'({o_busy, resQ.size() != 0, arrQ.size() != 0}), 64'(0));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"}, 64'({o_busy, o_done, o_row_rdy, o_sa_we, o_sa_a_vld,
                                   o_sa_c_vld, o_res_vld, o_res_last}), 64'(0));
    checkOutput({tag, "_arows"}, 64'(o_sa_a_rows), 64'(0));
    checkOutput({tag, "_resrow"}, 64'(o_res_row), 64'(0));
  endtask

  // One job: fill rows (with gaps), then either reset in CAPT or drain.
  task automatic applyStimulus(input mat_t a, input mat_t b, input int gap,
                               input int rdyMode, input bit poke, input bit doReset);
    row_t row;
    bit hs;
    bit ok;
    int d0;
    int drainCyc;
    for (int j = 0; j < S; j++)
      arrQ.push_back('{rows: b[S-1-j], we: (j == S - 1), cvld: 1'b0});
    for (int k = 0; k < S; k++) begin
      arrQ.push_back('{rows: a[k], we: 1'b0, cvld: 1'b1});
      resQ.push_back('{row: vecMat(a[k], b), last: (k == S - 1)});
    end
    d0 = doneCnt;
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int r = 0; r < 2 * S; r++) begin
      row = (r < S) ? b[r] : a[r - S];
      if (r > 0) begin
        for (int g = 0; g < gap; g++) begin
          i_row_vld = 1'b0;
          i_row = row_t'({$urandom, $urandom});
          @(posedge clk); #1;
        end
      end
      i_row_vld = 1'b1;
      i_row = row;
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        hs = o_row_rdy;
        @(posedge clk); #1;
        if (hs) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        checkOutput("fill_timeout", 64'(0), 64'(1));
        break;
      end
    end
    i_row_vld = 1'b0;

    if (doReset) begin
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (i_sa_c_vld) begin
          ok = 1;
          break;
        end
      end
      if (!ok) checkOutput("capt_timeout", 64'(0), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("abort");
      arrQ.delete();
      resQ.delete();
      d0 = doneCnt;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("no_done_after_abort", 64'(doneCnt), 64'(d0));
      return;
    end

    drainCyc = 0;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (doneCnt > d0) begin
        ok = 1;
        break;
      end
      case (rdyMode)
        0: i_res_rdy = 1'b1;
        1: i_res_rdy = 1'($urandom % 2);
        default: begin
          if (o_res_vld) begin
            i_res_rdy = (drainCyc < 5) ? 1'b0 : 1'(drainCyc % 2);
            drainCyc++;
          end else begin
            i_res_rdy = 1'b0;
          end
        end
      endcase
      i_start = poke && (o_sa_c_vld || o_res_vld);
    end
    i_start = 1'b0;
    if (!ok) begin
      checkOutput("done_timeout", 64'(0), 64'(1));
      arrQ.delete();
      resQ.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", 64'(doneCnt), 64'(d0 + 1));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    mat_t fa;
    mat_t ra;
    mat_t rb;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_row_vld = 1'b0;
    i_row = '0;
    i_res_rdy = 1'b0;
    #3;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    mkFixed(fa);
    $display("[TB] basic job");
    applyStimulus(fa, fa, 0, 0, 0, 0);
    $display("[TB] fill gaps");
    applyStimulus(fa, fa, 2, 0, 0, 0);
    $display("[TB] drain backpressure");
    applyStimulus(fa, fa, 0, 2, 0, 0);
    $display("[TB] ignored start then back-to-back job");
    applyStimulus(fa, fa, 0, 1, 1, 0);
    mkRandom(ra);
    mkRandom(rb);
    applyStimulus(ra, rb, 0, 0, 0, 0);
    $display("[TB] reset during capture");
    applyStimulus(fa, fa, 0, 0, 0, 1);
    applyStimulus(fa, fa, 0, 0, 0, 0);
    $display("[TB] random jobs");
    for (int n = 0; n < 6; n++) begin
      mkRandom(ra);
      mkRandom(rb);
      applyStimulus(ra, rb, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom % 2), 0);
    end
`ifdef SA_CTRL_VLD_CHECK_EN
    checkOutput("err_clean", 64'(o_err), 64'(0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
